// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module      : fetch_stage_if
// Description : Pipeline-side and instruction-memory signals of the fetch stage
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        if_valid;
   logic        fetch_stall;

   // The fetch stage itself
   modport master (
      input  freeze, branch_taken, branch_addr, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, instruction, pc_out, if_valid, fetch_stall
   );

   // Environment: decode/execute stages plus instruction memory
   modport slave (
      output freeze, branch_taken, branch_addr, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, instruction, pc_out, if_valid, fetch_stall
   );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with one outstanding read, stall and redirect
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'hE0000000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_WAIT    = 2'd1,
      S_READY   = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_inst_buf;
   logic [31:0] w_inst_nxt;
   logic [31:0] r_pc_last;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_addr;
   logic        w_req;
   logic        w_ready;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_ready    = (r_state == S_READY);
   assign w_addr     = bus.branch_taken ? bus.branch_addr :
                       (w_ready ? w_pc_plus4 : r_pc);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_inst_nxt  = r_inst_buf;
      w_req       = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            w_req       = 1'b1;
            w_pc_nxt    = w_addr;
            w_state_nxt = S_WAIT;
            if (bus.branch_taken) w_inst_nxt = NOP_INSTR;
         end
         S_WAIT: begin
            // A redirect while a read is in flight must let that read drain
            if (bus.branch_taken) begin
               w_pc_nxt    = bus.branch_addr;
               w_state_nxt = bus.imem_rvalid ? S_FETCH : S_DISCARD;
            end else if (bus.imem_rvalid) begin
               w_inst_nxt  = bus.imem_rdata;
               w_state_nxt = S_READY;
            end
         end
         S_READY: begin
            if (bus.branch_taken || !bus.freeze) begin
               w_req       = 1'b1;
               w_pc_nxt    = w_addr;
               w_state_nxt = S_WAIT;
               if (bus.branch_taken) w_inst_nxt = NOP_INSTR;
            end
         end
         S_DISCARD: begin
            if (bus.branch_taken) w_pc_nxt = bus.branch_addr;
            if (bus.imem_rvalid) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_pc       <= 32'd0;
         r_inst_buf <= NOP_INSTR;
         r_pc_last  <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_inst_buf <= w_inst_nxt;
         if (w_ready) r_pc_last <= w_pc_plus4;
      end
   end

   // FETCH requests combinationally, so the strobe is masked during reset
   assign bus.imem_req    = w_req & ~rst;
   assign bus.imem_addr   = w_addr;
   assign bus.if_valid    = w_ready;
   assign bus.fetch_stall = ~w_ready;
   assign bus.instruction = w_ready ? r_inst_buf : NOP_INSTR;
   assign bus.pc_out      = w_ready ? w_pc_plus4 : r_pc_last;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Randomized scoreboard bench for fetch_stage against a PC-stream model
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   localparam logic [31:0] c_nop = 32'hE0000000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_stage_if bus ();

   fetch_stage #(.NOP_INSTR(c_nop)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks     = 0;
   int          errors     = 0;
   int          deliveries = 0;
   int          idle_run   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_pc    = 32'd0;

   // Memory contents: distinct word per address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h3C5A_9617;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor and reference model: the model is the stream of PCs the
   // consumer should see -- sequential +4 on consume, redirected on branch.
   initial begin
      exp_q.push_back(32'd0);
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_if_valid", 32'(bus.if_valid), 32'd0);
            check("rst_imem_req", 32'(bus.imem_req), 32'd0);
            check("rst_instruction", bus.instruction, c_nop);
            check("rst_pc_out", bus.pc_out, 32'd0);
            exp_q.delete();
            exp_q.push_back(32'd0);
            last_pc  = 32'd0;
            idle_run = 0;
         end else begin
            if (bus.if_valid) begin
               check("stall_when_valid", 32'(bus.fetch_stall), 32'd0);
               check("instruction", bus.instruction, mem_word(exp_q[0]));
               check("pc_out", bus.pc_out, exp_q[0] + 32'd4);
               last_pc  = exp_q[0] + 32'd4;
               idle_run = 0;
            end else begin
               check("stall_when_idle", 32'(bus.fetch_stall), 32'd1);
               check("idle_instruction", bus.instruction, c_nop);
               check("idle_pc_out_hold", bus.pc_out, last_pc);
               if (bus.branch_taken) idle_run = 0;
               else idle_run++;
               if (idle_run > 12) begin
                  checks++;
                  errors++;
                  $display("FAIL delivery_timeout actual=%0d idle cycles required<=12", idle_run);
                  idle_run = 0;
               end
            end
            if (bus.if_valid && bus.freeze && !bus.branch_taken)
               check("frozen_no_req", 32'(bus.imem_req), 32'd0);
            if (bus.branch_taken) begin
               exp_q.delete();
               exp_q.push_back(bus.branch_addr);
            end else if (bus.if_valid && !bus.freeze) begin
               logic [31:0] p;
               p = exp_q.pop_front();
               exp_q.push_back(p + 32'd4);
               deliveries++;
            end
            if (bus.imem_req)
               check("imem_addr", bus.imem_addr, exp_q[0]);
         end
      end
   end

   // Instruction memory: one response per request, latency 1..3, drops on reset
   initial begin
      logic        busy;
      logic [31:0] maddr;
      int          lat;
      busy            = 1'b0;
      maddr           = 32'd0;
      lat             = 0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         if (!rst && bus.imem_req) begin
            checks++;
            if (busy) begin
               errors++;
               $display("FAIL single_outstanding actual=2 reads required<=1 t=%0t", $time);
            end
            busy  = 1'b1;
            maddr = bus.imem_addr;
            lat   = int'($urandom_range(1, 3));
         end
         @(posedge clk);
         #1;
         if (rst) begin
            busy            = 1'b0;
            bus.imem_rvalid = 1'b0;
         end else if (busy) begin
            lat--;
            if (lat == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = mem_word(maddr);
               busy            = 1'b0;
            end else begin
               bus.imem_rvalid = 1'b0;
               bus.imem_rdata  = $urandom;
            end
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
         end
      end
   end

   // Stimulus
   initial begin
      bit found;
      int n;
      bus.freeze       = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_addr  = 32'd0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      repeat (20) @(posedge clk);

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1;
         bus.freeze       = ($urandom_range(0, 99) < 35);
         bus.branch_taken = ($urandom_range(0, 99) < 8);
         case ($urandom_range(0, 3))
            0:       bus.branch_addr = 32'h0000_0040;
            1:       bus.branch_addr = 32'hFFFF_FFFC;
            2:       bus.branch_addr = 32'hFFFF_FFF8;
            default: bus.branch_addr = $urandom;
         endcase
      end
      @(posedge clk);
      #1;
      bus.freeze       = 1'b0;
      bus.branch_taken = 1'b0;

      // Asynchronous reset while a read is outstanding
      found = 1'b0;
      n     = 0;
      while (!found && n < 50) begin
         @(negedge clk);
         if (bus.imem_req) found = 1'b1;
         n++;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL find_request actual=none required=imem_req within 50 cycles");
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_if_valid", 32'(bus.if_valid), 32'd0);
      check("async_rst_imem_req", 32'(bus.imem_req), 32'd0);
      check("async_rst_instruction", bus.instruction, c_nop);
      check("async_rst_pc_out", bus.pc_out, 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      repeat (30) @(posedge clk);
      @(negedge clk);
      checks++;
      if (deliveries < 100) begin
         errors++;
         $display("FAIL delivery_count actual=%0d required>=100", deliveries);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
